// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART receive and transmit paths.
package uart_pkg;

  localparam int UART_CPC_W = 16;
  localparam int UART_BPF_W = 4;

  localparam logic [UART_BPF_W-1:0] UART_MIN_BITS = 4'd5;
  localparam logic [UART_BPF_W-1:0] UART_MAX_BITS = 4'd8;
  localparam logic [UART_CPC_W-1:0] UART_MIN_CPC  = 16'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // Bit period actually used: anything below two clocks cannot be mid-sampled.
  function automatic logic [UART_CPC_W-1:0] clamp_period(input logic [UART_CPC_W-1:0] cpc);
    if (cpc < UART_MIN_CPC) begin
      clamp_period = UART_MIN_CPC;
    end else begin
      clamp_period = cpc;
    end
  endfunction

  // Data bits per frame, limited to the 5..8 range the shift register supports.
  function automatic logic [UART_BPF_W-1:0] clamp_bits(input logic [UART_BPF_W-1:0] bpf);
    if (bpf < UART_MIN_BITS) begin
      clamp_bits = UART_MIN_BITS;
    end else if (bpf > UART_MAX_BITS) begin
      clamp_bits = UART_MAX_BITS;
    end else begin
      clamp_bits = bpf;
    end
  endfunction

  // Mask keeping only the low n bits of a byte (n is always 5..8 here).
  function automatic logic [7:0] data_mask(input logic [UART_BPF_W-1:0] nbits);
    data_mask = 8'hFF >> (4'd8 - nbits);
  endfunction

  // Two-out-of-three vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: loading value V raises o_tick exactly V cycles later.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [UART_CPC_W-1:0] i_value,
  output logic                  o_tick
);

  logic [UART_CPC_W-1:0] r_count;

  // Count register: a load always wins over the decrement; parks at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 16'd0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != 16'd0) begin
      r_count <= r_count - 16'd1;
    end else begin
      r_count <= r_count;
    end
  end

  // The count reads 1 in the V-th cycle after the load.
  assign o_tick = (r_count == 16'd1);

endmodule

// File: rtl/uart_frame_receiver.sv
// UART receive deframer: synchronises rx, detects the start bit, mid-samples
// each data bit and emits one byte per frame with a one-cycle strobe.
// Optional build macro UART_RX_GLITCH_FILTER_EN: 2-of-3 vote over the last
// three synchronised samples for start detection and every bit sample.
module uart_frame_receiver
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [UART_CPC_W-1:0] clocksPerCycle,
  input  logic [UART_BPF_W-1:0] bitsPerFrame,
  input  logic                  rx,
  output logic                  rxValid,
  output logic [7:0]            rxData,
  output logic                  frameError,
  output logic                  busy
);

  uart_state_e           r_state;
  uart_state_e           w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  w_rx_sync;
  logic                  w_sample;
  logic [UART_CPC_W-1:0] r_period;
  logic [UART_BPF_W-1:0] r_nbits;
  logic [UART_BPF_W-1:0] r_bit_cnt;
  logic [7:0]            r_shift;
  logic [7:0]            r_rx_data;
  logic                  r_rx_valid;
  logic                  r_frame_error;
  logic                  r_busy;
  logic                  w_tick;
  logic                  w_load;
  logic [UART_CPC_W-1:0] w_load_val;
  logic                  w_capture;
  logic                  w_cnt_clr;
  logic                  w_bit_we;
  logic                  w_valid_next;
  logic                  w_ferr_next;

  // Synchroniser chain; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign w_rx_sync = r_sync[SYNC_STAGES-1];

`ifdef UART_RX_GLITCH_FILTER_EN
  logic [1:0] r_hist;

  // Two previous synchronised samples; with the current one they form the vote window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rx_sync};
    end
  end

  assign w_sample = maj3(r_hist[1], r_hist[0], w_rx_sync);
`else
  assign w_sample = w_rx_sync;
`endif

  uart_bit_timer u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_tick  (w_tick)
  );

  // Next-state and control decode for the frame FSM.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = 16'd0;
    w_capture    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_bit_we     = 1'b0;
    w_valid_next = 1'b0;
    w_ferr_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_sample) begin
          w_load       = 1'b1;
          w_load_val   = clamp_period(clocksPerCycle) >> 1;
          w_capture    = 1'b1;
          w_state_next = START;
        end else begin
          w_state_next = IDLE;
        end
      end
      START: begin
        if (w_tick) begin
          if (!w_sample) begin
            w_load       = 1'b1;
            w_load_val   = r_period;
            w_cnt_clr    = 1'b1;
            w_state_next = DATA;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_state_next = START;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_bit_we   = 1'b1;
          w_load     = 1'b1;
          w_load_val = r_period;
          if (r_bit_cnt == (r_nbits - 4'd1)) begin
            w_state_next = STOP;
          end else begin
            w_state_next = DATA;
          end
        end else begin
          w_state_next = DATA;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (w_sample) begin
            w_valid_next = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = BREAK;
          end
        end else begin
          w_state_next = STOP;
        end
      end
      BREAK: begin
        // Wait for the line to go high so a held-low line cannot retrigger.
        if (w_rx_sync) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = BREAK;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // FSM state, latched frame configuration, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_period  <= UART_MIN_CPC;
      r_nbits   <= UART_MAX_BITS;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_period <= clamp_period(clocksPerCycle);
        r_nbits  <= clamp_bits(bitsPerFrame);
      end
      if (w_cnt_clr) begin
        r_bit_cnt <= 4'd0;
      end else if (w_bit_we) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_bit_we) begin
        r_shift[r_bit_cnt[2:0]] <= w_sample;
      end
    end
  end

  // Registered outputs: strobes, held data byte and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_valid    <= 1'b0;
      r_frame_error <= 1'b0;
      r_rx_data     <= 8'h00;
      r_busy        <= 1'b0;
    end else begin
      r_rx_valid    <= w_valid_next;
      r_frame_error <= w_ferr_next;
      r_busy        <= (w_state_next != IDLE);
      if (w_valid_next) begin
        r_rx_data <= r_shift & data_mask(r_nbits);
      end
    end
  end

  assign rxValid    = r_rx_valid;
  assign frameError = r_frame_error;
  assign rxData     = r_rx_data;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Self-checking bench for uart_frame_receiver: table-driven frames plus
// hand-written false-start, break, mid-frame reset and glitch sequences.
module tb_uart_frame_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpc;
  logic [3:0]  bpf;
  logic        rx;
  logic        rxValid;
  logic [7:0]  rxData;
  logic        frameError;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int         LAT     = 156;
  localparam logic [7:0] GL_EXP  = 8'hFF;
`else
  localparam int         LAT     = 155;
  localparam logic [7:0] GL_EXP  = 8'hEF;
`endif

  typedef struct {
    logic       is_ferr;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [15:0] cfg_cpc;
    logic [3:0]  cfg_bpf;
    int          period;
    int          nbits;
    logic [7:0]  data;
    logic [7:0]  exp_data;
    int          gap;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];
  int   last_valid_cyc = 0;
  bit   busy_seen = 1'b0;
  logic [7:0] last_good = 8'h00;

  uart_frame_receiver #(.SYNC_STAGES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .clocksPerCycle (cpc),
    .bitsPerFrame   (bpf),
    .rx             (rx),
    .rxValid        (rxValid),
    .rxData         (rxData),
    .frameError     (frameError),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame: start bit, nbits data bits LSB first, stop level for stop_len cycles.
  // glitch_bit selects a data bit that gets a one-cycle low pulse at its midpoint.
  task automatic send_frame(input logic [7:0] d, input int nbits, input int period,
                            input logic stop, input int stop_len, input int glitch_bit,
                            output int start_cyc);
    rx = 1'b0;
    start_cyc = cyc;
    tick(period);
    for (int k = 0; k < nbits; k++) begin
      for (int j = 0; j < period; j++) begin
        rx = (k == glitch_bit && j == period / 2) ? 1'b0 : d[k];
        tick(1);
      end
    end
    rx = stop;
    tick(stop_len);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick(1);
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  // Scoreboard monitor: every strobe pops one expectation, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_seen = 1'b1;
    if (!reset && (rxValid || frameError)) begin
      chk("strobe_exclusive", {31'd0, rxValid & frameError}, 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: rxValid=%0b frameError=%0b rxData=0x%0h, no frame pending",
                 rxValid, frameError, rxData);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind_ferr", {31'd0, frameError}, {31'd0, e.is_ferr});
        chk("rx_data", {24'd0, rxData}, {24'd0, e.data});
        if (rxValid) last_valid_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int sc;
    int sc0;

    tbl[0] = '{16'd16, 4'd8,  16, 8, 8'hA5, 8'hA5, 4};
    tbl[1] = '{16'd16, 4'd7,  16, 7, 8'h55, 8'h55, 0};
    tbl[2] = '{16'd16, 4'd7,  16, 7, 8'h2A, 8'h2A, 4};
    tbl[3] = '{16'd16, 4'd5,  16, 5, 8'hFF, 8'h1F, 4};
    tbl[4] = '{16'd16, 4'd3,  16, 5, 8'hEA, 8'h0A, 4};
    tbl[5] = '{16'd16, 4'd12, 16, 8, 8'hC3, 8'hC3, 4};
    tbl[6] = '{16'd1,  4'd8,  2,  8, 8'h96, 8'h96, 4};
    tbl[7] = '{16'd0,  4'd8,  2,  8, 8'h69, 8'h69, 4};
    tbl[8] = '{16'd24, 4'd6,  24, 6, 8'h2D, 8'h2D, 4};

    reset = 1'b1;
    rx    = 1'b1;
    cpc   = 16'd16;
    bpf   = 4'd8;
    sc0   = 0;
    tick(3);
    chk("reset_rxValid", {31'd0, rxValid}, 0);
    chk("reset_rxData", {24'd0, rxData}, 0);
    chk("reset_frameError", {31'd0, frameError}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    tick(4);

    // Table-driven good frames, including back-to-back and clamped configs.
    for (int i = 0; i < 9; i++) begin
      cpc = tbl[i].cfg_cpc;
      bpf = tbl[i].cfg_bpf;
      sb.push_back('{1'b0, tbl[i].exp_data});
      last_good = tbl[i].exp_data;
      send_frame(tbl[i].data, tbl[i].nbits, tbl[i].period, 1'b1, tbl[i].period, -1, sc);
      if (i == 0) sc0 = sc;
      if (tbl[i].gap != 0) begin
        tick(tbl[i].gap);
        wait_drain("drain_vec");
      end
      if (i == 0) chk("valid_latency", last_valid_cyc - sc0, LAT);
    end

    // False start: short low pulse, START samples high.
    cpc = 16'd16;
    bpf = 4'd8;
    tick(4);
    busy_seen = 1'b0;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    chk("false_start_busy_seen", {31'd0, busy_seen}, 1);
    chk("false_start_idle", {31'd0, busy}, 0);
    chk("false_start_no_strobe", sb.size(), 0);

    // Framing error with the line held low past the stop bit.
    sb.push_back('{1'b1, last_good});
    send_frame(8'hFF, 8, 16, 1'b0, 40, -1, sc);
    chk("break_busy", {31'd0, busy}, 1);
    chk("break_data_hold", {24'd0, rxData}, {24'd0, last_good});
    wait_drain("drain_ferr");
    rx = 1'b1;
    tick(6);
    chk("break_release", {31'd0, busy}, 0);

    // Reset in the middle of data bit 3 of 0x3C, then a clean 0x3C frame.
    rx = 1'b0;
    tick(16);
    for (int k = 0; k < 3; k++) begin
      rx = (k == 2) ? 1'b1 : 1'b0;
      tick(16);
    end
    rx = 1'b1;
    tick(8);
    reset = 1'b1;
    tick(3);
    chk("midreset_rxValid", {31'd0, rxValid}, 0);
    chk("midreset_rxData", {24'd0, rxData}, 0);
    chk("midreset_frameError", {31'd0, frameError}, 0);
    chk("midreset_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    tick(20);
    chk("midreset_no_strobe", sb.size(), 0);
    sb.push_back('{1'b0, 8'h3C});
    send_frame(8'h3C, 8, 16, 1'b1, 16, -1, sc);
    tick(4);
    wait_drain("drain_after_reset");

    // One-cycle low glitch at the midpoint of data bit 4 of 0xFF.
    sb.push_back('{1'b0, GL_EXP});
    send_frame(8'hFF, 8, 16, 1'b1, 16, 4, sc);
    tick(4);
    wait_drain("drain_glitch");
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_receiver.md
Name: uart_frame_receiver

Overview:
Standalone UART receive deframer, the counterpart of the existing transmitter.
- Synchronises the asynchronous rx line and detects the start bit.
- Samples each bit at its midpoint using the same clocksPerCycle / bitsPerFrame configuration format as the core.
- Emits one parallel byte per frame with a one-cycle valid strobe.
- Drops into the UART core alongside the transmitter; status and interrupt logic consume rxValid directly.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the rx synchroniser chain (legal >= 2)

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous and active-high (single clock domain)
clocksPerCycle  input  16  clock cycles per bit period
bitsPerFrame  input  4  data bits per frame
rx  input  1  asynchronous serial line, idle high
rxValid  output  1  one-cycle strobe: rxData holds a new byte
rxData  output  8  received data, bit k = k-th data bit received (LSB first)
frameError  output  1  one-cycle strobe: stop bit sampled low
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (synchronous): rxValid=0, rxData=8'h00, frameError=0, busy=0, FSM=IDLE, synchroniser flops=1, bit counter=0.
- Synchroniser: rx passes through SYNC_STAGES flops; rxSync is the last stage. The FSM only ever sees rxSync.
- Config capture: clocksPerCycle and bitsPerFrame are latched when the start edge is detected. Changes mid-frame take effect on the next frame.
  - Latched period N = max(clocksPerCycle, 2).
  - Latched bit count n = clamp(bitsPerFrame, 5, 8).
- Bit timer: down-counter. Loading value V produces a tick exactly V cycles later.
- IDLE:
  - On rxSync==0: load timer with N>>1, capture config, go to START.
- START: on tick, sample the line.
  - Sample 0: load timer with N, clear bit counter, go to DATA.
  - Sample 1 (false start): go to IDLE. No strobe.
- DATA: on tick, write the sample to the shift register at index bitCount, increment bitCount, reload timer with N.
  - After the n-th bit, go to STOP.
- STOP: on tick, sample the stop bit.
  - Sample 1: next cycle rxValid=1 and rxData = shift register with bits [7:n] forced to 0. Go to IDLE.
  - Sample 0: next cycle frameError=1, rxData unchanged, go to BREAK.
- BREAK: wait for rxSync==1, then go to IDLE. A held-low line therefore never retriggers a start.
- Latency: rxValid rises 1 cycle after the stop-bit sample point. The stop-bit sample point is the start-edge detection cycle + (N>>1) + n*N + N.
- Strobes: rxValid and frameError are mutually exclusive, each exactly one cycle wide.
- rxData holds its value until the next good frame.
- Back-to-back frames: a start edge arriving in the first IDLE cycle after STOP is accepted. There is no dead time beyond that one cycle.
- Reset mid-frame: the frame is abandoned, there is no strobe, and all outputs return to their reset values on the next edge.

Optional Feature:
UART_RX_GLITCH_FILTER_EN
- Defined: a 3-bit history of rxSync is kept. Every sample (start, data, stop) and the IDLE start detection use the majority of the last 3 values.
  - Start detection requires majority==0, which adds 1 cycle of start-detect latency.
  - Single-cycle glitches are rejected.
- Undefined: samples are the raw rxSync value; no history register is built.

Decomposition:
- Package uart_pkg:
  - State enum: IDLE, START, DATA, STOP, BREAK.
  - Constants: UART_MIN_BITS=5, UART_MAX_BITS=8, UART_MIN_CPC=2, UART_CPC_W=16, UART_BPF_W=4.
- Sub-module uart_bit_timer: 16-bit down-counter with load/value inputs and a tick output. It is reusable by the transmitter.

Test Plan:
- CPC=16, BPF=8, send 0xA5 with stop=1 -> one rxValid pulse; rxData=0xA5; pulse lands 1 cycle after the stop sample point (start edge +8+128+16 cycles); frameError stays 0.
- CPC=16, BPF=7, send 0x55 then 0x2A back-to-back -> two rxValid pulses, rxData=0x55 then 0x2A, bit 7=0 both times.
- CPC=16, rx low for 4 cycles then high -> busy pulses, START samples 1, return to IDLE; no rxValid, no frameError.
- CPC=16, BPF=8, send 0xFF with stop=0 held low for 40 cycles -> frameError one pulse, rxValid 0, rxData unchanged, busy stays 1 until rx returns high.
- CPC=16, assert reset at data bit 3 of 0x3C, then send 0x3C cleanly -> all outputs 0 during/after reset; second frame gives rxValid, rxData=0x3C.
- With UART_RX_GLITCH_FILTER_EN, CPC=16, 1-cycle low glitch on bit 4 of 0xFF -> rxData=0xFF. Without the macro, glitch aligned to the sample point -> rxData=0xEF.
